// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder.
// Latency: none, declarations only.
// Backpressure: not applicable.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;
    localparam int BCD_ADJ     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Operand/result handshake bundle for the serial BCD adder.
// Latency: none, wiring only.
// Backpressure: in_ready gates operand accept, out_ready releases the result.
// The digit_err signal exists only when BCD_SERIAL_DIGIT_ERR_EN is defined.
interface bcd_serial_add_ctrl_if #(
    parameter int DIGITS = 100
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  busy;
`ifdef BCD_SERIAL_DIGIT_ERR_EN
    logic                  digit_err;
`endif

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, a, b, cin, out_ready,
`ifdef BCD_SERIAL_DIGIT_ERR_EN
        input  digit_err,
`endif
        input  in_ready, out_valid, sum, cout, busy
    );

    // The adder block itself.
    modport slave (
        input  in_valid, a, b, cin, out_ready,
`ifdef BCD_SERIAL_DIGIT_ERR_EN
        output digit_err,
`endif
        output in_ready, out_valid, sum, cout, busy
    );

endinterface

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder with decimal adjust.
// Latency: combinational.
// Backpressure: none.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout
);

    logic [BCD_DIGIT_W:0] s;

    // Binary sum of the digit pair, then add 6 when it overflows a decimal digit.
    // The 5-bit intermediate keeps non-BCD inputs (up to 31) from wrapping early.
    always_comb begin
        s = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
        if (s > (BCD_DIGIT_W+1)'(BCD_MAX)) begin
            sum  = s[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(BCD_ADJ);
            cout = 1'b1;
        end else begin
            sum  = s[BCD_DIGIT_W-1:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Packed-BCD adder that reuses one digit adder, one digit per clock, LSB first.
// Latency: result valid DIGITS cycles after accept; one op per DIGITS+2 cycles.
// Backpressure: result held until out_ready; no accept while running or holding.
// Optional digit_err output enabled by defining BCD_SERIAL_DIGIT_ERR_EN.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 100
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_serial_add_ctrl_if.slave bus
);

    localparam int W  = BCD_DIGIT_W * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            carry_q;
    logic [W-1:0]    sum_q;
    logic            cout_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;

    int              dig_idx;
    bcd_digit_t      a_k;
    bcd_digit_t      b_k;
    bcd_digit_t      d_sum;
    logic            d_cout;

    // Select the operand digits addressed by the digit counter.
    always_comb begin
        dig_idx = int'(cnt) * BCD_DIGIT_W;
        a_k     = a_q[dig_idx +: BCD_DIGIT_W];
        b_k     = b_q[dig_idx +: BCD_DIGIT_W];
    end

    bcd_digit_adder u_digit (
        .a    (a_k),
        .b    (b_k),
        .cin  (carry_q),
        .sum  (d_sum),
        .cout (d_cout)
    );

`ifdef BCD_SERIAL_DIGIT_ERR_EN
    logic err_q;
    assign bus.digit_err = err_q;
`endif

    // Controller: accept operands, walk the digits, then hold the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef BCD_SERIAL_DIGIT_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        carry_q    <= bus.cin;   // digit 0 picks up cin via the carry register
                        cnt        <= '0;
                        state      <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef BCD_SERIAL_DIGIT_ERR_EN
                        err_q      <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    sum_q[dig_idx +: BCD_DIGIT_W] <= d_sum;
                    carry_q <= d_cout;
`ifdef BCD_SERIAL_DIGIT_ERR_EN
                    if ((a_k > BCD_DIGIT_W'(BCD_MAX)) || (b_k > BCD_DIGIT_W'(BCD_MAX)))
                        err_q <= 1'b1;
`endif
                    if (cnt == LAST_CNT) begin
                        cout_q      <= d_cout;
                        state       <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    // in_ready rises only after this edge, so no same-cycle re-accept.
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl with DIGITS=4: directed operations, a
// cycle-level decimal reference model checked every cycle, and literal results.
// Define BCD_SERIAL_DIGIT_ERR_EN to also exercise digit_err.
module tb_bcd_serial_add_ctrl;
    import bcd_pkg::*;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: decimal arithmetic for valid BCD, digit-by-digit rule otherwise.
    function automatic logic [W:0] bcd_ref(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int va, vb, tot, p, s, cc;
        bit ok;
        logic [W-1:0] r;
        ok = 1'b1;
        va = 0; vb = 0; p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (int'(x[4*i +: 4]) > 9 || int'(y[4*i +: 4]) > 9) ok = 1'b0;
            va += int'(x[4*i +: 4]) * p;
            vb += int'(y[4*i +: 4]) * p;
            p  *= 10;
        end
        r = '0;
        if (ok) begin
            tot = va + vb + int'(c);
            cc  = (tot >= p) ? 1 : 0;
            tot = tot % p;
            for (int i = 0; i < DIGITS; i++) begin
                r[4*i +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end else begin
            cc = int'(c);
            for (int i = 0; i < DIGITS; i++) begin
                s = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + cc;
                if (s > 9) begin r[4*i +: 4] = 4'((s + 6) % 16); cc = 1; end
                else       begin r[4*i +: 4] = 4'(s);            cc = 0; end
            end
        end
        return {cc[0], r};
    endfunction

    function automatic bit has_bad_digit(input logic [W-1:0] x, input logic [W-1:0] y);
        bit bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (int'(x[4*i +: 4]) > 9 || int'(y[4*i +: 4]) > 9) bad = 1'b1;
        return bad;
    endfunction

    // Cycle model: remaining RUN cycles, result-held flag, last result.
    int           m_left  = 0;
    bit           m_done  = 1'b0;
    bit           m_hold  = 1'b0;
    bit           started = 1'b0;
    logic [W-1:0] m_sum   = '0;
    logic         m_cout  = 1'b0;
    bit           m_err   = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("in_ready",  32'(bus.in_ready),  32'(m_left == 0 && !m_done));
                check("busy",      32'(bus.busy),      32'(m_left > 0));
                check("out_valid", 32'(bus.out_valid), 32'(m_done));
                if (m_done || m_hold) begin
                    check("sum",  32'(bus.sum),  32'(m_sum));
                    check("cout", 32'(bus.cout), 32'(m_cout));
`ifdef BCD_SERIAL_DIGIT_ERR_EN
                    check("digit_err", 32'(bus.digit_err), 32'(m_err));
`endif
                end
            end
            if (reset) begin
                started = 1'b1;
                m_left = 0; m_done = 1'b0; m_hold = 1'b1;
                m_sum = '0; m_cout = 1'b0; m_err = 1'b0;
            end else if (started) begin
                if (m_left == 0 && !m_done) begin
                    if (bus.in_valid) begin
                        {m_cout, m_sum} = bcd_ref(bus.a, bus.b, bus.cin);
                        m_err  = has_bad_digit(bus.a, bus.b);
                        m_left = DIGITS;
                        m_hold = 1'b0;
                    end
                end else if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) m_done = 1'b1;
                end else if (bus.out_ready) begin
                    m_done = 1'b0;
                    m_hold = 1'b1;
                end
            end
        end
    end

    // One full operation with literal expectations; starts and ends at posedge+1.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic [W-1:0] es, input logic ec, input int hold);
        int n;
        bit ok;
        bus.out_ready = (hold == 0);
        bus.a = ta; bus.b = tb_v; bus.cin = tc; bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.cin = ~tc;
        n = 0; ok = 1'b0;
        while (!ok && n < 50) begin
            @(posedge clk); #1;
            n++;
            ok = bus.out_valid;
        end
        check("latency", 32'(n), 32'(DIGITS));
        check("lit_sum",  32'(bus.sum),  32'(es));
        check("lit_cout", 32'(bus.cout), 32'(ec));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_ready", 32'(bus.in_ready),  32'd0);
            check("hold_sum",   32'(bus.sum),       32'(es));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready",  32'(bus.in_ready),  32'd1);
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_sum",       32'(bus.sum),       32'd0);
        check("rst_cout",      32'(bus.cout),      32'd0);
        reset = 1'b0;

        // Carry ripples across three digits.
        run_op(16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 0);
        // cin propagates all the way out; then back-to-back op.
        run_op(16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1, 0);
        run_op(16'h4567, 16'h5678, 1'b0, 16'h0245, 1'b1, 0);
        // Consumer stalls for five cycles.
        run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 5);

        // Abort mid-run with counter at 2.
        bus.out_ready = 1'b1;
        bus.a = 16'h1234; bus.b = 16'h1111; bus.cin = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("abort_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_in_ready",  32'(bus.in_ready),  32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy_low",  32'(bus.busy),      32'd0);
        check("abort_sum",       32'(bus.sum),       32'd0);
        check("abort_cout",      32'(bus.cout),      32'd0);
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 0);

        // in_valid toggling with other operands during RUN is ignored.
        bus.out_ready = 1'b1;
        bus.a = 16'h0005; bus.b = 16'h0005; bus.cin = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < DIGITS; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.a = 16'h8888; bus.b = 16'h0000;
            check("run_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("toggle_valid", 32'(bus.out_valid), 32'd1);
        check("toggle_sum",   32'(bus.sum),       32'h0010);
        check("toggle_cout",  32'(bus.cout),      32'd0);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("toggle_idle", 32'(bus.in_ready), 32'd1);
        run_op(16'h8888, 16'h0000, 1'b0, 16'h8888, 1'b0, 0);

`ifdef BCD_SERIAL_DIGIT_ERR_EN
        run_op(16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 0);
        check("digit_err_set", 32'(bus.digit_err), 32'd1);
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 0);
        check("digit_err_clr", 32'(bus.digit_err), 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
Sequencer that performs a DIGITS-wide packed-BCD addition by time-multiplexing one single-digit BCD adder, one digit per clock, from LSB to MSB.
- Area-reduced alternative to a fully unrolled ripple chain of digit adders.
- Accepts an operand pair through a valid/ready handshake and returns sum and carry-out through a valid/ready handshake.
- Intended for slow control-path arithmetic, e.g. BCD counters and display accumulators.

Parameters:
DIGITS, 100, number of BCD digits per operand (>=1); datapath width is 4*DIGITS.

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand pair (a, b, cin) is presented
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  4*DIGITS  packed BCD operand A; digit i = a[4i+3:4i]
b  input  4*DIGITS  packed BCD operand B
cin  input  1  carry into digit 0
out_valid  output  1  sum/cout hold a completed result
out_ready  input  1  consumer accepts the result
sum  output  4*DIGITS  packed BCD result
cout  output  1  carry out of digit DIGITS-1
busy  output  1  high in RUN

Behaviour:
- Reset values (sync reset): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, digit counter=0.
- Reset asserted in any state, including mid-RUN, aborts the operation. No partial result is ever presented.
- FSM has three states:
  - IDLE: in_ready=1. On in_valid: latch a, b and cin into operand registers, clear counter, go to RUN.
  - RUN: busy=1, in_ready=0. Each cycle, digit k=counter is computed from latched a_k, b_k and the carry register (cin for k=0). The result is written to sum[4k+3:4k] and the carry register is updated.
    - If k==DIGITS-1: cout = final carry, go to DONE.
    - Else: counter increments.
  - DONE: out_valid=1. sum and cout are stable. When out_ready=1, go to IDLE at that edge.
- Digit arithmetic:
  - s = a_k + b_k + c, as a 5-bit binary value (range 0..31 even for non-BCD input).
  - If s>9: digit=(s+6)[3:0], carry=1.
  - Else: digit=s[3:0], carry=0.
- Latency: handshake accepted at edge E; out_valid rises after edge E+DIGITS. Throughput is one operation per DIGITS+2 cycles minimum.
- Handshake rules:
  - in_ready is 0 in RUN and DONE. in_valid in those states is ignored and the inputs are not sampled.
  - An accept cannot occur in the same cycle as a DONE->IDLE transition.
  - out_valid stays high until out_ready. sum/cout must not change while out_valid=1.
- After DONE->IDLE, sum/cout keep the last result until the next accept. Digits of sum not yet written in RUN may hold stale values; they are not observable because out_valid=0.
- a/b may change freely after the accept; only the latched copies are used.
- DIGITS=1: RUN lasts exactly one cycle.
- Counter width is max(1, clog2(DIGITS)). It never exceeds DIGITS-1.

Optional Feature:
Macro BCD_SERIAL_DIGIT_ERR_EN.
- Defined:
  - Adds output port digit_err (1 bit, reset 0).
  - Set during RUN when a latched a_k or b_k exceeds 9; sticky for the current operation.
  - Cleared on accept.
  - Valid alongside out_valid.
  - Arithmetic is unchanged.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_DIGIT_W=4, BCD_MAX=9, BCD_ADJ=6;
  - enum state_t {IDLE, RUN, DONE};
  - typedef bcd_digit_t (logic [3:0]).
- One combinational sub-module, bcd_digit_adder: inputs a, b, cin; outputs sum, cout. It implements the digit arithmetic above and has a 4-bit datapath. It is instantiated once.
- Controller FSM, counter, operand registers and result register live in bcd_serial_add_ctrl.

Test Plan:
All scenarios use DIGITS=4.
1. a=0999, b=0001, cin=0, out_ready=1 -> out_valid after exactly 4 cycles, sum=1000, cout=0, then in_ready=1 the next cycle.
2. a=9999, b=0000, cin=1 -> sum=0000, cout=1. Then a=4567, b=5678, cin=0 back-to-back -> sum=0245, cout=1.
3. Backpressure: result of 1234+4321 with out_ready held 0 for 5 cycles -> out_valid stays 1, sum=5555 stable, in_ready=0. out_ready=1 -> IDLE next cycle.
4. Assert reset for one cycle while counter=2 in RUN -> next cycle IDLE, out_valid=0, sum=0000, cout=0. A fresh 0001+0001 then gives 0002.
5. Toggle in_valid with a=8888 during RUN of a 0005+0005 operation -> result 0010, cout=0; the second operand pair is not accepted until IDLE.
6. With BCD_SERIAL_DIGIT_ERR_EN defined:
   - a=00A0, b=0000, cin=0 -> digit_err=1 at out_valid; sum digit 1=(10+6)[3:0]=0 with carry, sum=0100.
   - A following valid 0001+0001 -> digit_err=0.
